// File: rtl/buffer_mult_seq.sv
// Command sequencer for one buffer_mult instance.
// Loads weights into the buffer and runs signed dot-products over it.
module buffer_mult_seq #(
    parameter int DEPTH    = 16,
    parameter int DW       = 8,
    parameter int ACC_W    = 12,
    parameter int MULT_LAT = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic             cmd_op,
    input  logic [AW:0]      cmd_len,
    output logic             cmd_ready,
    input  logic             w_valid,
    input  logic [DW-1:0]    w_data,
    output logic             w_ready,
    input  logic             a_valid,
    input  logic [DW-1:0]    a_data,
    output logic             a_ready,
    output logic [DW-1:0]    buf_A,
    output logic [DW-1:0]    buf_wrb_data,
    output logic [AW-1:0]    buf_wrb_addr,
    output logic             buf_wrb,
    output logic [AW-1:0]    buf_rdb_addr,
    input  logic [DW-1:0]    buf_data_out,
    output logic             res_valid,
    output logic [ACC_W-1:0] res_data,
    output logic             done,
    output logic             err,
    output logic             busy
);

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AW:0]             len_q;
    logic [AW:0]             loaded_len;
    logic [AW:0]             wcnt;
    logic [AW:0]             icnt;
    logic [AW:0]             ocnt;
    logic                    op_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] res_q;
    logic signed [ACC_W-1:0] prod_ext;
    logic [MULT_LAT-1:0]     pipe;

    logic cmd_hs;
    logic len_ok;
    logic go_load;
    logic go_run;
    logic cmd_bad;
    logic w_hs;
    logic a_hs;
    logic last_w;
    logic last_a;
    logic pipe_out;
    logic drain_done;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign w_ready   = (state == S_LOAD);
    assign a_ready   = (state == S_RUN) && (icnt < len_q);
    assign done      = (state == S_FIN);
    assign res_valid = (state == S_FIN) && op_q;
    assign res_data  = res_q;
    assign prod_ext  = {{(ACC_W-DW){buf_data_out[DW-1]}}, buf_data_out};

    // Command legality, stream handshakes and completion conditions.
    always_comb begin
        len_ok     = (cmd_len != '0) && (cmd_len <= LEN_MAX);
        cmd_hs     = (state == S_IDLE) && cmd_valid;
        go_load    = 1'b0;
        go_run     = 1'b0;
        unique case (1'b1)
            (cmd_hs && !cmd_op): go_load = len_ok;
            (cmd_hs && cmd_op):  go_run  = len_ok && (cmd_len <= loaded_len);
            default: ;
        endcase
        cmd_bad    = cmd_hs && !go_load && !go_run;
        w_hs       = w_valid && w_ready;
        a_hs       = a_valid && a_ready;
        last_w     = w_hs && ((wcnt + ONE) == len_q);
        last_a     = a_hs && ((icnt + ONE) == len_q);
        pipe_out   = pipe[MULT_LAT-1];
        drain_done = (ocnt == len_q);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                unique case (1'b1)
                    go_load: state_nxt = S_LOAD;
                    go_run:  state_nxt = S_RUN;
                    default: state_nxt = S_IDLE;
                endcase
            end
            S_LOAD: begin
                if (last_w) begin
                    state_nxt = S_FIN;
                end
            end
            S_RUN: begin
                if (last_a) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch, stream counters and the loaded-length record.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q      <= '0;
            op_q       <= 1'b0;
            wcnt       <= '0;
            icnt       <= '0;
            ocnt       <= '0;
            loaded_len <= '0;
            err        <= 1'b0;
        end else begin
            err <= cmd_bad;
            if (go_load || go_run) begin
                len_q <= cmd_len;
                op_q  <= cmd_op;
                wcnt  <= '0;
                icnt  <= '0;
                ocnt  <= '0;
            end else begin
                if (w_hs) begin
                    wcnt <= wcnt + ONE;
                end
                if (a_hs) begin
                    icnt <= icnt + ONE;
                end
                if (pipe_out) begin
                    ocnt <= ocnt + ONE;
                end
            end
            if (last_w) begin
                loaded_len <= len_q;
            end
        end
    end

    // Buffer write port, registered one cycle after each weight handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_wrb      <= 1'b0;
            buf_wrb_addr <= '0;
            buf_wrb_data <= '0;
        end else begin
            buf_wrb <= w_hs;
            if (w_hs) begin
                buf_wrb_addr <= wcnt[AW-1:0];
                buf_wrb_data <= w_data;
            end
        end
    end

    // Buffer read port and multiplier operand; hold while the stream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_rdb_addr <= '0;
            buf_A        <= '0;
        end else if (a_hs) begin
            buf_rdb_addr <= icnt[AW-1:0];
            buf_A        <= a_data;
        end
    end

    // Issue pipe tracks which cycles carry a real product back from the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe <= '0;
        end else begin
            pipe[0] <= a_hs;
            for (int i = 1; i < MULT_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Accumulator and the result register that holds between runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            res_q <= '0;
        end else begin
            if (go_run) begin
                acc <= '0;
            end else if (pipe_out) begin
                acc <= acc + prod_ext;
            end
            if ((state == S_DRAIN) && drain_done) begin
                res_q <= acc;
            end
        end
    end

endmodule

// File: tb/tb_buffer_mult_seq.sv
// Directed bench for buffer_mult_seq.
// A behavioural buffer_mult returns A * stored weight, truncated to DW bits.
module tb_buffer_mult_seq;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int ACC_W = 12;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_op;
    logic [AW:0]      cmd_len;
    logic             cmd_ready;
    logic             w_valid;
    logic [DW-1:0]    w_data;
    logic             w_ready;
    logic             a_valid;
    logic [DW-1:0]    a_data;
    logic             a_ready;
    logic [DW-1:0]    buf_A;
    logic [DW-1:0]    buf_wrb_data;
    logic [AW-1:0]    buf_wrb_addr;
    logic             buf_wrb;
    logic [AW-1:0]    buf_rdb_addr;
    logic [DW-1:0]    buf_data_out;
    logic             res_valid;
    logic [ACC_W-1:0] res_data;
    logic             done;
    logic             err;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [DW-1:0]   mem   [DEPTH];
    logic signed [DW-1:0]   w_vec [DEPTH];
    logic signed [DW-1:0]   a_vec [DEPTH];
    logic signed [2*DW-1:0] prod;

    always #5 clk = ~clk;

    buffer_mult_seq dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_len      (cmd_len),
        .cmd_ready    (cmd_ready),
        .w_valid      (w_valid),
        .w_data       (w_data),
        .w_ready      (w_ready),
        .a_valid      (a_valid),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .buf_A        (buf_A),
        .buf_wrb_data (buf_wrb_data),
        .buf_wrb_addr (buf_wrb_addr),
        .buf_wrb      (buf_wrb),
        .buf_rdb_addr (buf_rdb_addr),
        .buf_data_out (buf_data_out),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .done         (done),
        .err          (err),
        .busy         (busy)
    );

    always @(posedge clk) begin
        if (buf_wrb) mem[buf_wrb_addr] <= buf_wrb_data;
    end

    assign prod         = $signed(buf_A) * mem[buf_rdb_addr];
    assign buf_data_out = prod[DW-1:0];

    task automatic send_cmd(input logic op, input int len);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len[AW:0];
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_len   = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cmd_ready, busy, buf_wrb, done, err, res_valid} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 100000",
                     {cmd_ready, busy, buf_wrb, done, err, res_valid});
        end
        n_checks++;
        if ({buf_A, buf_wrb_data, buf_wrb_addr, buf_rdb_addr, res_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: A=%h wd=%h wa=%h ra=%h res=%h want 0",
                     buf_A, buf_wrb_data, buf_wrb_addr, buf_rdb_addr, res_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load(input int len, input string name);
        send_cmd(1'b0, len);
        for (int i = 0; i < len; i++) begin
            n_checks++;
            if (w_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s w_ready[%0d]: got %b want 1", name, i, w_ready);
            end
            w_valid = 1'b1;
            w_data  = w_vec[i];
            @(negedge clk);
            n_checks++;
            if (buf_wrb !== 1'b1 || buf_wrb_addr !== i[AW-1:0] ||
                buf_wrb_data !== w_vec[i]) begin
                n_fail++;
                $display("FAIL %s write[%0d]: got wrb=%b addr=%0d data=%0d want 1 %0d %0d",
                         name, i, buf_wrb, buf_wrb_addr, $signed(buf_wrb_data),
                         i, w_vec[i]);
            end
            n_checks++;
            if (done !== (i == len - 1) || err !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done[%0d]: got done=%b err=%b want %b 0",
                         name, i, done, err, (i == len - 1));
            end
        end
        w_valid = 1'b0;
        w_data  = '0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || buf_wrb !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after: got done=%b busy=%b wrb=%b want 0 0 0",
                     name, done, busy, buf_wrb);
        end
    endtask

    task automatic test_run(input int len, input bit gap,
                            input logic signed [ACC_W-1:0] exp,
                            input string name);
        int  issued;
        int  cyc;
        bit  got;
        bit  hs;
        issued = 0;
        cyc    = 0;
        got    = 1'b0;
        send_cmd(1'b1, len);
        while (!got && cyc < 200) begin
            if (issued < len && (!gap || cyc % 2 == 0)) begin
                a_valid = 1'b1;
                a_data  = a_vec[issued];
            end else begin
                a_valid = 1'b0;
            end
            hs = a_valid && a_ready;
            @(negedge clk);
            cyc++;
            if (hs) begin
                n_checks++;
                if (buf_rdb_addr !== issued[AW-1:0] || buf_A !== a_vec[issued]) begin
                    n_fail++;
                    $display("FAIL %s issue[%0d]: got addr=%0d A=%0d want %0d %0d",
                             name, issued, buf_rdb_addr, $signed(buf_A),
                             issued, a_vec[issued]);
                end
                issued++;
            end
            if (done === 1'b1) begin
                got = 1'b1;
                n_checks++;
                if (res_valid !== 1'b1 || res_data !== exp || issued != len) begin
                    n_fail++;
                    $display("FAIL %s result: got rv=%b res=%0d issued=%0d want 1 %0d %0d",
                             name, res_valid, $signed(res_data), issued, exp, len);
                end
            end else begin
                n_checks++;
                if (res_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s early_res_valid: got %b want 0", name, res_valid);
                end
            end
        end
        a_valid = 1'b0;
        a_data  = '0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got no done want done", name);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 ||
            res_data !== exp) begin
            n_fail++;
            $display("FAIL %s pulse_end: got done=%b rv=%b busy=%b res=%0d want 0 0 0 %0d",
                     name, done, res_valid, busy, $signed(res_data), exp);
        end
    endtask

    task automatic test_illegal(input logic op, input int len, input string name);
        send_cmd(op, len);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s err: got err=%b busy=%b rdy=%b want 1 0 1",
                     name, err, busy, cmd_ready);
        end
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s err_pulse: got err=%b busy=%b done=%b want 0 0 0",
                     name, err, busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        send_cmd(1'b1, 16);
        for (int i = 0; i < 2; i++) begin
            a_valid = 1'b1;
            a_data  = a_vec[i];
            @(negedge clk);
        end
        a_valid = 1'b0;
        a_data  = '0;
        reset   = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, busy, buf_wrb, done, err, res_valid} !== 6'b100000) begin
            n_fail++;
            $display("FAIL midrst_ctl: got %b want 100000",
                     {cmd_ready, busy, buf_wrb, done, err, res_valid});
        end
        n_checks++;
        if ({buf_A, buf_rdb_addr, res_data} !== '0) begin
            n_fail++;
            $display("FAIL midrst_data: A=%h ra=%h res=%h want 0",
                     buf_A, buf_rdb_addr, res_data);
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_quiet: got rv=%b done=%b busy=%b want 0 0 0",
                         res_valid, done, busy);
            end
        end
        test_illegal(1'b1, 1, "run_after_reset");
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_len   = '0;
        w_valid   = 1'b0;
        w_data    = '0;
        a_valid   = 1'b0;
        a_data    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]   = '0;
            w_vec[i] = '0;
            a_vec[i] = '0;
        end

        test_reset();

        for (int i = 0; i < 5; i++) w_vec[i] = 8'(i + 2);
        test_load(5, "load5");

        for (int i = 0; i < 5; i++) a_vec[i] = 8'(i + 1);
        test_run(5, 1'b0, 12'sd70, "run5");

        for (int i = 0; i < 4; i++) a_vec[i] = -8'sd1;
        test_run(4, 1'b1, -12'sd14, "run4_gap");

        test_illegal(1'b0, 0, "len0");
        test_illegal(1'b0, 17, "len17");
        test_illegal(1'b1, 6, "run6_over");

        for (int i = 0; i < DEPTH; i++) w_vec[i] = 8'sd127;
        test_load(16, "load16");

        for (int i = 0; i < DEPTH; i++) a_vec[i] = 8'sd1;
        test_run(16, 1'b0, 12'sd2032, "run16");

        test_reset_mid_run();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/buffer_mult_seq.md
Name: buffer_mult_seq

Overview:
- Sequencer for the 16-entry weight-buffer multiplier (buffer_mult).
- Load command: streams weights into the buffer through the write port.
- Run command: streams activations and issues matching buffer reads, then accumulates the signed 8-bit products into one dot-product result.
- Sits between the layer controller, which issues commands, and one buffer_mult instance. Owns all of that instance's control inputs.

Parameters:
- DEPTH, 16, buffer entries; address width AW = $clog2(DEPTH).
- DW, 8, signed data width of weights, activations and products.
- ACC_W, 12, accumulator width; must be at least DW + AW, so no overflow is possible.
- MULT_LAT, 1, cycles from buffer read address/A being presented to a valid buf_data_out (range 1..4).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command strobe, accepted only in IDLE
- cmd_op  in  1  0 = load weights, 1 = run dot-product
- cmd_len  in  AW+1  tap count, legal range 1..DEPTH
- cmd_ready  out  1  high only in IDLE
- w_valid  in  1  weight stream valid
- w_data  in  DW  signed weight
- w_ready  out  1  high in LOAD
- a_valid  in  1  activation stream valid
- a_data  in  DW  signed activation
- a_ready  out  1  high in RUN while issued < len
- buf_A  out  DW  to buffer_mult A
- buf_wrb_data  out  DW  to buffer_mult wrb_data
- buf_wrb_addr  out  AW  to buffer_mult wrb_addr
- buf_wrb  out  1  to buffer_mult wrb
- buf_rdb_addr  out  AW  to buffer_mult rdb_addr
- buf_data_out  in  DW  from buffer_mult data_out, signed product
- res_valid  out  1  one-cycle result strobe
- res_data  out  ACC_W  signed dot-product
- done  out  1  one-cycle pulse at the end of every accepted command
- err  out  1  one-cycle pulse when a command is rejected
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high) values:
  - State goes to IDLE.
  - All counters, acc, loaded_len and the issue pipe clear to 0.
  - buf_wrb, res_valid, done and err are 0.
  - buf_* data and address outputs are 0.
  - Reset mid-operation aborts the command. No done, no res_valid. Any queued write is dropped.
- FSM states: IDLE, LOAD, RUN, DRAIN, FIN.
- IDLE:
  - cmd_valid with cmd_len in 1..DEPTH and cmd_op = 0 goes to LOAD; latch len.
  - cmd_op = 1 and cmd_len <= loaded_len goes to RUN; latch len and clear acc.
  - Any other command (len 0, len > DEPTH, or run with len > loaded_len) pulses err the next cycle and stays in IDLE.
- LOAD:
  - Each cycle with w_valid && w_ready registers buf_wrb = 1, buf_wrb_addr = wcnt, buf_wrb_data = w_data; wcnt increments.
  - buf_wrb is 0 in every cycle without a handshake. A write is visible on the ports exactly one cycle after its handshake.
  - After handshake number len: w_ready drops the same cycle, loaded_len <= len, and the FSM goes to FIN.
- RUN:
  - Each a_valid && a_ready handshake registers buf_rdb_addr = icnt and buf_A = a_data.
  - A 1 is shifted into an issue pipe of depth MULT_LAT; a cycle without a handshake shifts in 0. icnt increments.
  - buf_A and buf_rdb_addr hold their last values while idle. buf_wrb is always 0 in RUN and DRAIN.
  - After handshake number len, a_ready drops and the FSM goes to DRAIN.
- Accumulation (RUN and DRAIN): when the pipe output is 1, acc <= acc + sign-extended buf_data_out. This happens exactly MULT_LAT cycles after the ports were presented. Products are counted in ocnt.
- DRAIN: when ocnt reaches len, goes to FIN. The result is ready no later than MULT_LAT+1 cycles after the last issue.
- FIN, one cycle:
  - done = 1.
  - If the command was a run: res_valid = 1 and res_data = acc. res_data holds until the next run's FIN.
  - Then goes to IDLE.
- Back-to-back commands: cmd_ready is high in IDLE only, so the minimum gap between accepted commands is 2 cycles (FIN, IDLE).
- A load with len < DEPTH leaves the upper entries unchanged. loaded_len takes the most recent load's len.
- Stalls: gaps in w_valid or a_valid are tolerated anywhere. Counters hold during gaps.

Test Plan:
- Reset then load len 5, w = 2,3,4,5,6, with no gaps:
  - buf_wrb high for 5 consecutive cycles at addr 0..4.
  - done one cycle after the last write is presented; err = 0.
- Run len 5 after that load, A = 1,2,3,4,5, with the buffer model returning A*w:
  - rdb_addr sequence 0..4.
  - res_data = 2+6+12+20+30 = 70; res_valid and done are coincident single pulses.
- Run len 4 with a_valid toggling every other cycle, A = -1 each, weights 2,3,4,5:
  - res_data = -14.
  - No accumulation occurs in gap cycles.
- Full depth: load len 16, all weights 127, then run len 16 with all A = 1 and the model returning 127:
  - res_data = 2032.
  - Addresses wrap cleanly at 15.
- Illegal commands:
  - len 0, len 17, or run len 6 when loaded_len = 5: each gives err one pulse, FSM stays in IDLE, busy stays 0.
- Reset asserted during RUN after 2 issues:
  - All outputs return to reset values the next cycle, with no res_valid.
  - A subsequent run is rejected with err, because loaded_len was cleared.
